// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
// Command/response peer that sits behind a UART controller. Received bytes are assembled into
// request frames (0x55, CMD, ADDR, DATA[, CSUM]), a single register-bus access is performed, and a
// response frame (0xAA, STATUS, RDATA[, RCSUM]) is returned one byte at a time. Consecutive transmit
// strobes are separated by BYTE_GAP idle cycles, so the transmitter is never overrun.
//
// Optional feature macro: UART_CMD_CHECKSUM_EN
//   defined     : 5-byte request with CSUM = CMD^ADDR^DATA, 4-byte response with RCSUM = STATUS^RDATA
//   not defined : 4-byte request, 3-byte response, bad-checksum status never produced
//
// Ports
//   uart_clk_in    in   1  clock, rising edge
//   reset          in   1  synchronous active-high reset
//   uart_rx_data   in   8  received byte, valid with uart_rx_done
//   uart_rx_done   in   1  one-cycle strobe per received byte
//   uart_tx_data   out  8  byte to transmit, held until the next strobe
//   uart_tx_enable out  1  one-cycle start strobe per transmitted byte
//   reg_addr       out  8  register address (valid while executing)
//   reg_wdata      out  8  register write data (valid while executing)
//   reg_wr_en      out  1  one-cycle write strobe
//   reg_rd_en      out  1  one-cycle read strobe; reg_rdata is taken one cycle later
//   reg_rdata      in   8  register read data
//   busy           out  1  high from header accepted until the last response gap expires
//   frame_err      out  1  one-cycle pulse when a partial frame is dropped on timeout
module uart_cmd_responder #(
   parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
   parameter logic [31:0] UART_BAUD  = 32'd115200,
   parameter logic [31:0] RX_TIMEOUT = 32'd1_000_000
) (
   input  logic       uart_clk_in,
   input  logic       reset,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_rx_done,
   output logic [7:0] uart_tx_data,
   output logic       uart_tx_enable,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr_en,
   output logic       reg_rd_en,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic       frame_err
);

   // One start bit, eight data bits, stop bit and a spare bit time per byte.
   localparam logic [31:0] BYTE_GAP = (CLK_FREQ / UART_BAUD) * 32'd11;

`ifdef UART_CMD_CHECKSUM_EN
   localparam logic [1:0] LAST_TX_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_TX_IDX = 2'd2;
`endif

   localparam logic [7:0] SYNC_REQ = 8'h55;
   localparam logic [7:0] SYNC_RSP = 8'hAA;
   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] ST_OK    = 8'h00;
   localparam logic [7:0] ST_CSUM  = 8'h01;
   localparam logic [7:0] ST_CMD   = 8'h02;

   typedef enum logic [3:0] {
      S_IDLE, S_RX_CMD, S_RX_ADDR, S_RX_DATA, S_RX_CSUM,
      S_EXEC, S_RD_WAIT, S_TX_BYTE, S_TX_WAIT
   } state_t;

   // Three-way XOR used for both the request and response checksums.
   function automatic logic [7:0] xor3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      return a ^ b ^ c;
   endfunction

   // Response byte for a given position in the outgoing frame.
   function automatic logic [7:0] resp_byte(input logic [1:0] idx, input logic [7:0] st, input logic [7:0] rd);
      logic [7:0] b;
      case (idx)
         2'd0:    b = SYNC_RSP;
         2'd1:    b = st;
         2'd2:    b = rd;
         2'd3:    b = xor3(st, rd, 8'h00);
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
   logic [7:0]  status_q, status_d, rdata_q, rdata_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  tx_data_q, tx_data_d, reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
   logic        tx_en_q, tx_en_d, reg_wr_en_q, reg_wr_en_d, reg_rd_en_q, reg_rd_en_d;
   logic        busy_q, busy_d, frame_err_q, frame_err_d;
   logic        csum_ok_s;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]  csum_q, csum_d;
`endif

   // Next-state and next-output logic; outputs are computed for the state being entered so the
   // registered outputs line up with the state they belong to.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      data_d      = data_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      idx_d       = idx_q;
      tx_data_d   = tx_data_q;
      tx_en_d     = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_wr_en_d = 1'b0;
      reg_rd_en_d = 1'b0;
      frame_err_d = 1'b0;
      csum_ok_s   = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (uart_rx_done && (uart_rx_data == SYNC_REQ)) begin
               state_d = S_RX_CMD;
               cnt_d   = 32'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RX_CMD, S_RX_ADDR, S_RX_DATA, S_RX_CSUM: begin
            // A byte arriving on the expiry cycle is still taken.
            if (uart_rx_done) begin
               cnt_d = 32'd0;
               case (state_q)
                  S_RX_CMD:  begin cmd_d  = uart_rx_data; state_d = S_RX_ADDR; end
                  S_RX_ADDR: begin addr_d = uart_rx_data; state_d = S_RX_DATA; end
`ifdef UART_CMD_CHECKSUM_EN
                  S_RX_DATA: begin data_d = uart_rx_data; state_d = S_RX_CSUM; end
                  S_RX_CSUM: begin csum_d = uart_rx_data; state_d = S_EXEC;    end
`else
                  S_RX_DATA: begin data_d = uart_rx_data; state_d = S_EXEC;    end
`endif
                  default:   state_d = S_IDLE;
               endcase
            end else if (cnt_q >= (RX_TIMEOUT - 32'd1)) begin
               frame_err_d = 1'b1;
               cnt_d       = 32'd0;
               state_d     = S_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_EXEC: begin
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            // Read data arrives one cycle after the read strobe.
            if ((cmd_q == CMD_RD) && (status_q == ST_OK)) begin
               rdata_d = reg_rdata;
            end else begin
               rdata_d = rdata_q;
            end
            idx_d   = 2'd0;
            state_d = S_TX_BYTE;
         end
         S_TX_BYTE: begin
            cnt_d   = 32'd0;
            state_d = S_TX_WAIT;
         end
         S_TX_WAIT: begin
            if (cnt_q >= (BYTE_GAP - 32'd1)) begin
               cnt_d = 32'd0;
               if (idx_q == LAST_TX_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_TX_BYTE;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
         end
      endcase

`ifdef UART_CMD_CHECKSUM_EN
      csum_ok_s = (csum_d == xor3(cmd_d, addr_d, data_d));
`endif

      // Command decode on entry to EXEC so the bus strobes are visible during EXEC.
      if (state_d == S_EXEC) begin
         reg_addr_d  = addr_d;
         reg_wdata_d = data_d;
         if (!csum_ok_s) begin
            status_d = ST_CSUM;
            rdata_d  = 8'h00;
         end else if (cmd_d == CMD_WR) begin
            reg_wr_en_d = 1'b1;
            status_d    = ST_OK;
            rdata_d     = data_d;
         end else if (cmd_d == CMD_RD) begin
            reg_rd_en_d = 1'b1;
            status_d    = ST_OK;
            rdata_d     = 8'h00;
         end else begin
            status_d = ST_CMD;
            rdata_d  = 8'h00;
         end
      end else begin
         reg_addr_d  = reg_addr_q;
         reg_wdata_d = reg_wdata_q;
      end

      // Byte load and start strobe on entry to TX_BYTE.
      if (state_d == S_TX_BYTE) begin
         tx_en_d   = 1'b1;
         tx_data_d = resp_byte(idx_d, status_d, rdata_d);
      end else begin
         tx_en_d   = 1'b0;
         tx_data_d = tx_data_q;
      end

      busy_d = (state_d != S_IDLE);
   end

   // State, counters, frame fields and registered outputs.
   always_ff @(posedge uart_clk_in) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 32'd0;
         cmd_q       <= 8'h00;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         status_q    <= 8'h00;
         rdata_q     <= 8'h00;
         idx_q       <= 2'd0;
         tx_data_q   <= 8'h00;
         tx_en_q     <= 1'b0;
         reg_addr_q  <= 8'h00;
         reg_wdata_q <= 8'h00;
         reg_wr_en_q <= 1'b0;
         reg_rd_en_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
         csum_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
         idx_q       <= idx_d;
         tx_data_q   <= tx_data_d;
         tx_en_q     <= tx_en_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_wr_en_q <= reg_wr_en_d;
         reg_rd_en_q <= reg_rd_en_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign uart_tx_data   = tx_data_q;
   assign uart_tx_enable = tx_en_q;
   assign reg_addr       = reg_addr_q;
   assign reg_wdata      = reg_wdata_q;
   assign reg_wr_en      = reg_wr_en_q;
   assign reg_rd_en      = reg_rd_en_q;
   assign busy           = busy_q;
   assign frame_err      = frame_err_q;

endmodule
